hazard_scoreboard: RTL and testbench
====================================

// Module: hazard_scoreboard
// PURPOSE
//   Issue controller for the decode stage. Tracks destination registers of in-flight
//   instructions in a 32-entry scoreboard and holds decode (issue_ready=0) on RAW/WAW
//   hazards or when the in-flight limit is reached. Clears entries on writeback and
//   supports a pipeline flush. Sits between decode and the writeback port of the
//   register file.
// PARAMETERS
//   MAX_INFLIGHT  4  max un-retired writing instructions (1..15)
//   WB_BYPASS     1  1: writeback this cycle satisfies a hazard this cycle (rf write-through)
//   STALL_CNT_W   16 width of saturating stall-cycle counter
// PORTS
//   clock            in   1   rising-edge clock
//   reset_n          in   1   synchronous active-low reset
//   issue_valid      in   1   decode presents an instruction
//   issue_rs1        in   5   source register 1
//   issue_rs2        in   5   source register 2
//   issue_use_rs1    in   1   rs1 is read
//   issue_use_rs2    in   1   rs2 is read
//   issue_rd         in   5   destination register
//   issue_write_rd   in   1   instruction writes rd
//   issue_ready      out  1   instruction accepted this cycle when issue_valid=1
//   wb_valid         in   1   writeback retiring a register write
//   wb_addr          in   5   register being written back
//   flush            in   1   discard all in-flight instructions
//   pending_mask     out  32  scoreboard bits (bit0 always 0)
//   inflight_count   out  4   number of pending writes
//   stall_cycles     out  STALL_CNT_W  saturating count of cycles with issue_valid && !issue_ready
//   wb_error         out  1   sticky: writeback to register not pending
// BEHAVIOUR
//   - Reset (reset_n=0 at posedge): pending_mask=0, inflight_count=0, stall_cycles=0,
//     wb_error=0, state=RUN. Reset wins over every other input, mid-flush included.
//   - clr = wb_valid & pending[wb_addr] (WB_BYPASS=1) else 0; eff = pending & ~(clr<<wb_addr).
//   - hazard = (use_rs1 & eff[rs1]) | (use_rs2 & eff[rs2]) | (write_rd & eff[rd]);
//     x0 never hazards, never set.
//   - full = write_rd & (rd!=0) & (inflight_count == MAX_INFLIGHT) & !(wb_valid & pending[wb_addr]).
//   - FSM: RUN, STALL, FLUSH. issue_ready = (state!=FLUSH) & !flush & !hazard & !full
//     (combinational on inputs and state; zero-cycle latency).
//     RUN->STALL: issue_valid & !issue_ready & !flush. STALL->RUN: issue_ready | !issue_valid.
//     any->FLUSH: flush=1. FLUSH->RUN after exactly one cycle with flush=0.
//   - Update at posedge (issue = issue_valid & issue_ready & write_rd & rd!=0):
//     set bit rd on issue; clear bit wb_addr on wb_valid when pending; set wins if
//     same register both; inflight_count +1 on issue, -1 on valid clear, unchanged if both.
//   - wb_valid to non-pending reg (or x0): no state change except wb_error<=1 (x0: no error).
//   - flush: pending_mask<=0, inflight_count<=0 next cycle; same-cycle issue/wb ignored;
//     wb_error and stall_cycles preserved.
//   - stall_cycles increments on issue_valid & !issue_ready, saturates at all-ones.
// TESTING
//   1 reset, issue rd=5 then rs1=5 -> cycle2 issue_ready=0, pending_mask=0x20, count=1.
//   2 wb_valid addr=5 same cycle as rs1=5 issue -> ready=1 (BYPASS=1), mask clears to 0.
//   3 issue rd=1..4 back-to-back, then rd=6 -> ready=0 (full); wb addr=1 same cycle -> ready=1, count stays 4.
//   4 rd=0 / rs1=0 issues -> always ready, mask stays 0, count 0; wb addr=0 -> wb_error=0.
//   5 mask=0x1E, flush=1 with issue rd=7 -> ready=0, next cycle mask=0, count=0, FLUSH->RUN.
//   6 wb addr=9 not pending -> wb_error=1 sticky; 3 stalled cycles -> stall_cycles=3; reset clears both.

Source files
------------

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: decode-stage issue control tracking in-flight destination registers for RAW/WAW hazards
// Ports: clock/reset_n (sync active-low); issue_* decode request, issue_ready accept;
//   wb_valid/wb_addr retire a pending write; flush drops all in-flight writes;
//   pending_mask scoreboard, inflight_count pending writes, stall_cycles saturating stall count,
//   wb_error sticky flag for writeback to a non-pending register.
module hazard_scoreboard #(
  parameter int MAX_INFLIGHT = 4,
  parameter bit WB_BYPASS = 1'b1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   issue_valid,
  input  logic [4:0]             issue_rs1,
  input  logic [4:0]             issue_rs2,
  input  logic                   issue_use_rs1,
  input  logic                   issue_use_rs2,
  input  logic [4:0]             issue_rd,
  input  logic                   issue_write_rd,
  output logic                   issue_ready,
  input  logic                   wb_valid,
  input  logic [4:0]             wb_addr,
  input  logic                   flush,
  output logic [31:0]            pending_mask,
  output logic [3:0]             inflight_count,
  output logic [STALL_CNT_W-1:0] stall_cycles,
  output logic                   wb_error
);
  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;
  state_t state;
  logic [31:0] wb_bit, rd_bit, eff;
  logic wb_hit, hazard, full, issue;
  always_comb begin
    wb_bit = 32'd1 << wb_addr;
    rd_bit = 32'd1 << issue_rd;
    // bit 0 is never set, so a writeback to x0 never hits
    wb_hit = wb_valid & pending_mask[wb_addr];
    eff = (WB_BYPASS && wb_hit) ? (pending_mask & ~wb_bit) : pending_mask;
    hazard = (issue_use_rs1 & eff[issue_rs1]) | (issue_use_rs2 & eff[issue_rs2]) |
             (issue_write_rd & eff[issue_rd]);
    full = issue_write_rd & (issue_rd != 5'd0) &
           (inflight_count == 4'(MAX_INFLIGHT)) & ~wb_hit;
    issue_ready = (state != FLUSH) & ~flush & ~hazard & ~full;
    issue = issue_valid & issue_ready & issue_write_rd & (issue_rd != 5'd0);
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= RUN;
      pending_mask <= '0;
      inflight_count <= '0;
      stall_cycles <= '0;
      wb_error <= 1'b0;
    end else begin
      if (issue_valid && !issue_ready && stall_cycles != '1)
        stall_cycles <= stall_cycles + 1'b1;
      if (flush) begin
        state <= FLUSH;
        pending_mask <= '0;
        inflight_count <= '0;
      end else begin
        // FLUSH always lasts exactly one flush-free cycle; RUN/STALL follow the stall condition
        state <= (state != FLUSH && issue_valid && !issue_ready) ? STALL : RUN;
        // clear first, then set, so a same-register issue keeps the bit
        pending_mask <= (pending_mask & ~(wb_hit ? wb_bit : 32'd0)) | (issue ? rd_bit : 32'd0);
        inflight_count <= inflight_count + 4'(issue) - 4'(wb_hit);
        if (wb_valid && !wb_hit && wb_addr != 5'd0)
          wb_error <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed and randomized checks of hazard_scoreboard against a register-array model
module tb_hazard_scoreboard;
  localparam int MAXI = 4;
  localparam int SW = 4;
  localparam int SMAX = (1 << SW) - 1;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic issue_valid = 0, issue_use_rs1 = 0, issue_use_rs2 = 0, issue_write_rd = 0;
  logic [4:0] issue_rs1 = 0, issue_rs2 = 0, issue_rd = 0, wb_addr = 0;
  logic wb_valid = 0, flush = 0;
  logic issue_ready, wb_error;
  logic [31:0] pending_mask;
  logic [3:0] inflight_count;
  logic [SW-1:0] stall_cycles;
  int checks = 0, errors = 0;
  bit pend[32];
  int cnt, stalls;
  bit in_flush, err;
  always #5 clock = ~clock;
  hazard_scoreboard #(.MAX_INFLIGHT(MAXI), .WB_BYPASS(1'b1), .STALL_CNT_W(SW)) dut (
    .clock(clock), .reset_n(reset_n), .issue_valid(issue_valid),
    .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_use_rs1(issue_use_rs1), .issue_use_rs2(issue_use_rs2),
    .issue_rd(issue_rd), .issue_write_rd(issue_write_rd), .issue_ready(issue_ready),
    .wb_valid(wb_valid), .wb_addr(wb_addr), .flush(flush),
    .pending_mask(pending_mask), .inflight_count(inflight_count),
    .stall_cycles(stall_cycles), .wb_error(wb_error)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic bit busy(input logic [4:0] r);
    return r != 0 && pend[r] && !(wb_valid && wb_addr == r);
  endfunction
  function automatic bit model_ready();
    bit hz, fl;
    hz = (issue_use_rs1 && busy(issue_rs1)) || (issue_use_rs2 && busy(issue_rs2)) ||
         (issue_write_rd && busy(issue_rd));
    fl = issue_write_rd && issue_rd != 0 && cnt == MAXI &&
         !(wb_valid && wb_addr != 0 && pend[wb_addr]);
    return !in_flush && !flush && !hz && !fl;
  endfunction
  function automatic logic [31:0] model_mask();
    logic [31:0] m = '0;
    for (int i = 0; i < 32; i++) m[i] = pend[i];
    return m;
  endfunction
  task automatic model_update(input bit r);
    if (!reset_n) begin
      foreach (pend[i]) pend[i] = 0;
      cnt = 0; in_flush = 0; err = 0; stalls = 0;
      return;
    end
    if (issue_valid && !r && stalls < SMAX) stalls++;
    if (flush) begin
      foreach (pend[i]) pend[i] = 0;
      cnt = 0; in_flush = 1;
      return;
    end
    in_flush = 0;
    if (wb_valid && wb_addr != 0) begin
      if (pend[wb_addr]) begin pend[wb_addr] = 0; cnt--; end
      else err = 1;
    end
    if (issue_valid && r && issue_write_rd && issue_rd != 0) begin
      pend[issue_rd] = 1; cnt++;
    end
  endtask
  task automatic drive(input bit v, input int rs1, input bit u1, input int rd, input bit w,
                       input bit wv, input int wa, input bit fl);
    issue_valid = v; issue_rs1 = 5'(rs1); issue_use_rs1 = u1; issue_rs2 = 0; issue_use_rs2 = 0;
    issue_rd = 5'(rd); issue_write_rd = w; wb_valid = wv; wb_addr = 5'(wa); flush = fl;
  endtask
  task automatic step();
    bit r;
    #1;
    r = model_ready();
    if (reset_n) chk("issue_ready", 32'(issue_ready), 32'(r));
    @(posedge clock);
    model_update(r);
    #1;
    chk("pending_mask", pending_mask, model_mask());
    chk("inflight_count", 32'(inflight_count), 32'(cnt));
    chk("stall_cycles", 32'(stall_cycles), 32'(stalls));
    chk("wb_error", 32'(wb_error), 32'(err));
  endtask
  task automatic ready_is(input string tag, input bit exp);
    #1;
    chk(tag, 32'(issue_ready), 32'(exp));
  endtask
  initial begin
    int wa;
    reset_n = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step(); step();
    chk("reset_mask", pending_mask, 32'h0);
    chk("reset_count", 32'(inflight_count), 32'h0);
    reset_n = 1;
    drive(1, 0, 0, 5, 1, 0, 0, 0); ready_is("t1_issue5", 1); step();
    chk("t1_mask", pending_mask, 32'h20);
    chk("t1_count", 32'(inflight_count), 32'd1);
    drive(1, 5, 1, 0, 0, 0, 0, 0); ready_is("t1_raw", 0); step();
    drive(1, 5, 1, 0, 0, 1, 5, 0); ready_is("t2_bypass", 1); step();
    chk("t2_mask", pending_mask, 32'h0);
    for (int i = 1; i <= 4; i++) begin drive(1, 0, 0, i, 1, 0, 0, 0); step(); end
    drive(1, 0, 0, 6, 1, 0, 0, 0); ready_is("t3_full", 0); step();
    drive(1, 0, 0, 6, 1, 1, 1, 0); ready_is("t3_full_wb", 1); step();
    chk("t3_count", 32'(inflight_count), 32'd4);
    chk("t3_mask", pending_mask, 32'h5C);
    for (int i = 2; i <= 6; i += (i == 4) ? 2 : 1) begin drive(0, 0, 0, 0, 0, 1, i, 0); step(); end
    drive(1, 0, 1, 0, 1, 0, 0, 0); ready_is("t4_x0", 1); step();
    drive(1, 0, 1, 0, 1, 1, 0, 0); step();
    chk("t4_mask", pending_mask, 32'h0);
    chk("t4_err", 32'(wb_error), 32'h0);
    for (int i = 1; i <= 4; i++) begin drive(1, 0, 0, i, 1, 0, 0, 0); step(); end
    chk("t5_pre", pending_mask, 32'h1E);
    drive(1, 0, 0, 7, 1, 0, 0, 1); ready_is("t5_flush", 0); step();
    chk("t5_mask", pending_mask, 32'h0);
    chk("t5_count", 32'(inflight_count), 32'h0);
    drive(1, 0, 0, 7, 1, 0, 0, 0); ready_is("t5_flushstate", 0); step();
    drive(1, 0, 0, 7, 1, 0, 0, 0); ready_is("t5_run", 1); step();
    reset_n = 0; drive(0, 0, 0, 0, 0, 0, 0, 0); step(); reset_n = 1;
    drive(0, 0, 0, 0, 0, 1, 9, 0); step();
    chk("t6_err", 32'(wb_error), 32'h1);
    drive(1, 0, 0, 10, 1, 0, 0, 0); step();
    for (int i = 0; i < 3; i++) begin drive(1, 10, 1, 0, 0, 0, 0, 0); step(); end
    chk("t6_stall", 32'(stall_cycles), 32'd3);
    chk("t6_sticky", 32'(wb_error), 32'h1);
    reset_n = 0; drive(0, 0, 0, 0, 0, 0, 0, 0); step(); reset_n = 1;
    chk("t6_rst_stall", 32'(stall_cycles), 32'h0);
    chk("t6_rst_err", 32'(wb_error), 32'h0);
    for (int n = 0; n < 600; n++) begin
      wa = $urandom_range(0, 9);
      if ($urandom_range(0, 4) != 0)
        for (int k = 0; k < 8; k++) begin
          int c = $urandom_range(1, 7);
          if (pend[c]) begin wa = c; break; end
        end
      issue_valid = $urandom_range(0, 3) != 0;
      issue_rs1 = 5'($urandom_range(0, 7)); issue_use_rs1 = 1'($urandom);
      issue_rs2 = 5'($urandom_range(0, 7)); issue_use_rs2 = 1'($urandom);
      issue_rd = 5'($urandom_range(0, 7)); issue_write_rd = $urandom_range(0, 3) != 0;
      wb_valid = $urandom_range(0, 2) == 0; wb_addr = 5'(wa);
      flush = $urandom_range(0, 24) == 0;
      reset_n = $urandom_range(0, 149) != 0;
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
